cache_block_fill_8way: RTL and testbench

- Write-side counterpart of the 8-way 256-bit block read select.
- Accepts a cache-line refill from memory as 8 sequential 32-bit beats and assembles them into one 256-bit block.
- Commits the block into exactly one of 8 ways with a one-hot, single-cycle write strobe.
- Sits between the memory refill interface and the per-way block data arrays.

---
 rtl/cache_block_fill_8way.sv | 138 +++++++++++++
 tb/tb_cache_block_fill_8way.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_block_fill_8way.sv
// Assembles an 8-beat memory refill into a 256-bit block and commits it to one way.
// Optional macro CRITICAL_WORD_FIRST_EN adds fill_word / crit_valid (critical-word-first order).
module cache_block_fill_8way #(
    parameter int WORD_W = 32,
    parameter int BEATS  = 8,
    parameter int WAYS   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fill_start,
    input  logic [$clog2(WAYS)-1:0]    fill_way,
`ifdef CRITICAL_WORD_FIRST_EN
    input  logic [$clog2(BEATS)-1:0]   fill_word,
    output logic                       crit_valid,
`endif
    input  logic                       fill_abort,
    input  logic [WORD_W-1:0]          mem_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    output logic [WAYS-1:0]            way_we,
    output logic [WORD_W*BEATS-1:0]    blockIn,
    output logic                       busy,
    output logic                       fill_done
);
    localparam int IDX_W = $clog2(BEATS);
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [IDX_W-1:0]   cnt_r;
    logic [WAY_W-1:0]   way_r;
    logic [WAY_W-1:0]   way_nx_s;
    logic [IDX_W-1:0]   idx_s;
    logic               start_s;
    logic               beat_s;
`ifdef CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0]   base_r;
`endif

    // Next-state decode; abort outranks a final beat, and a beat is only taken in FILL.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        beat_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (fill_start) begin
                    state_nx_s = FILL;
                    start_s    = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FILL: begin
                if (fill_abort) begin
                    state_nx_s = IDLE;
                end else if (mem_valid) begin
                    beat_s = 1'b1;
                    if (cnt_r == IDX_W'(BEATS - 1)) begin
                        state_nx_s = COMMIT;
                    end else begin
                        state_nx_s = FILL;
                    end
                end else begin
                    state_nx_s = FILL;
                end
            end
            COMMIT:  state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Target way and the word slot for the current beat (wraps because BEATS is a power of two).
    always_comb begin
        if (start_s) begin
            way_nx_s = fill_way;
        end else begin
            way_nx_s = way_r;
        end
`ifdef CRITICAL_WORD_FIRST_EN
        idx_s = cnt_r + base_r;
`else
        idx_s = cnt_r;
`endif
    end

    // State, beat assembly and registered outputs computed from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {IDX_W{1'b0}};
            way_r      <= {WAY_W{1'b0}};
            blockIn    <= {(WORD_W*BEATS){1'b0}};
            way_we     <= {WAYS{1'b0}};
            mem_ready  <= 1'b0;
            busy       <= 1'b0;
            fill_done  <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            base_r     <= {IDX_W{1'b0}};
            crit_valid <= 1'b0;
`endif
        end else begin
            state_r <= state_nx_s;
            way_r   <= way_nx_s;
            if (start_s) begin
                cnt_r <= {IDX_W{1'b0}};
            end else if (beat_s) begin
                cnt_r <= cnt_r + IDX_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (beat_s) begin
                blockIn[idx_s*WORD_W +: WORD_W] <= mem_data;
            end
            mem_ready <= (state_nx_s == FILL);
            busy      <= (state_nx_s != IDLE);
            fill_done <= (state_nx_s == COMMIT);
            if (state_nx_s == COMMIT) begin
                way_we <= WAYS'(1) << way_nx_s;
            end else begin
                way_we <= {WAYS{1'b0}};
            end
`ifdef CRITICAL_WORD_FIRST_EN
            if (start_s) begin
                base_r <= fill_word;
            end
            crit_valid <= beat_s && (cnt_r == {IDX_W{1'b0}});
`endif
        end
    end

endmodule

// File: tb/tb_cache_block_fill_8way.sv
// Table-driven bench for cache_block_fill_8way with a commit scoreboard and a block model.
module tb_cache_block_fill_8way;
    logic         clk;
    logic         rst;
    logic         fill_start;
    logic [2:0]   fill_way;
    logic [2:0]   fill_word;
    logic         fill_abort;
    logic [31:0]  mem_data;
    logic         mem_valid;
    logic         mem_ready;
    logic [7:0]   way_we;
    logic [255:0] blockIn;
    logic         busy;
    logic         fill_done;
    logic         crit_valid;

    cache_block_fill_8way dut (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .fill_way   (fill_way),
`ifdef CRITICAL_WORD_FIRST_EN
        .fill_word  (fill_word),
        .crit_valid (crit_valid),
`endif
        .fill_abort (fill_abort),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .way_we     (way_we),
        .blockIn    (blockIn),
        .busy       (busy),
        .fill_done  (fill_done)
    );

`ifndef CRITICAL_WORD_FIRST_EN
    assign crit_valid = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [2:0]  way;
        logic [2:0]  word;
        logic [15:0] vmask;      // per-cycle mem_valid pattern
        int          abort_at;   // beat index at which abort rides along with the beat (-1 none)
        int          intrude_at; // beat index at which a stray fill_start is driven (-1 none)
        logic [31:0] seed;
        logic [7:0]  exp_we;     // expected strobe (0 = no commit)
    } vec_t;

    typedef struct {
        logic [7:0]   we;
        logic [255:0] blk;
    } exp_t;

    vec_t         vecs[$];
    exp_t         sb_q[$];
    logic [255:0] model_blk;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc_cnt  = 0;
    int           crit_seen = 0;
    int           crit_exp  = 0;
    bit           started  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] way, input logic [2:0] word,
                                input logic [15:0] vmask, input int abort_at, input int intrude_at,
                                input logic [31:0] seed, input logic [7:0] exp_we);
        vec_t v;
        v.name = nm; v.way = way; v.word = word; v.vmask = vmask; v.abort_at = abort_at;
        v.intrude_at = intrude_at; v.seed = seed; v.exp_we = exp_we;
        return v;
    endfunction

    // Scoreboard: every strobe must match the next expected commit; fill_done never appears alone.
    always @(negedge clk) begin
        exp_t e;
        if (crit_valid === 1'b1) crit_seen++;
        if (way_we != 8'h00) begin
            if (sb_q.size() == 0) begin
                check("unexpected_way_we", {248'd0, way_we}, 256'd0);
            end else begin
                e = sb_q.pop_front();
                check("way_we", {248'd0, way_we}, {248'd0, e.we});
                check("blockIn_commit", blockIn, e.blk);
                check("fill_done_with_we", {255'd0, fill_done}, 256'd1);
            end
        end else if (started && fill_done === 1'b1) begin
            check("fill_done_alone", {255'd0, fill_done}, 256'd0);
        end
    end

    // Runs one fill from a negedge; returns cycles from start sample to commit (0 if none).
    task automatic do_fill(input vec_t v, output int lat);
        int n = 0;
        int c = 0;
        int start_cyc;
        bit aborted = 1'b0;
        bit crit_chk = 1'b0;
        logic [2:0]  idx;
        logic [31:0] d;
        exp_t e;
        lat = 0;
        fill_start = 1'b1;
        fill_way   = v.way;
        fill_word  = v.word;
        start_cyc  = cyc_cnt;
        @(negedge clk);
        fill_start = 1'b0;
        check({v.name, "_mem_ready"}, {255'd0, mem_ready}, 256'd1);
        check({v.name, "_busy"}, {255'd0, busy}, 256'd1);
        while (n < 8 && !aborted && c < 64) begin
            mem_valid  = v.vmask[c % 16];
            d          = v.seed * (n + 1);
            mem_data   = d;
            fill_abort = (v.abort_at == n) && mem_valid;
            if (v.intrude_at == n) begin
                fill_start = 1'b1;
                fill_way   = v.way - 3'd1;
            end
            if (fill_abort) begin
                aborted = 1'b1;
            end else if (mem_valid) begin
`ifdef CRITICAL_WORD_FIRST_EN
                idx = v.word + n[2:0];
`else
                idx = n[2:0];
`endif
                model_blk[idx*32 +: 32] = d;
                if (n == 7) begin
                    e.we  = v.exp_we;
                    e.blk = model_blk;
                    sb_q.push_back(e);
                end
                n++;
            end
            @(negedge clk);
            fill_start = 1'b0;
            c++;
`ifdef CRITICAL_WORD_FIRST_EN
            if (n == 1 && !crit_chk && !aborted) begin
                crit_chk = 1'b1;
                crit_exp++;
                check({v.name, "_crit_valid"}, {255'd0, crit_valid}, 256'd1);
                check({v.name, "_crit_word"}, {224'd0, blockIn[v.word*32 +: 32]}, {224'd0, v.seed});
            end
`endif
        end
        mem_valid  = 1'b0;
        fill_abort = 1'b0;
        if (aborted) begin
            check({v.name, "_busy_after_abort"}, {255'd0, busy}, 256'd0);
            check({v.name, "_we_after_abort"}, {248'd0, way_we}, 256'd0);
        end else if (n < 8) begin
            check({v.name, "_fill_timeout"}, n, 8);
        end else begin
            lat = cyc_cnt - start_cyc;
            @(negedge clk);
            check({v.name, "_busy_idle"}, {255'd0, busy}, 256'd0);
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1; fill_start = 1'b0; fill_way = 3'd0; fill_word = 3'd0;
        fill_abort = 1'b0; mem_data = 32'd0; mem_valid = 1'b0;
        model_blk = 256'd0;

        vecs.push_back(mk("basic",     3'd5, 3'd0, 16'hFFFF, -1, -1, 32'h11111111, 8'h20));
        vecs.push_back(mk("stall",     3'd0, 3'd0, 16'h9999, -1, -1, 32'h01020304, 8'h01));
        vecs.push_back(mk("abort3",    3'd4, 3'd0, 16'hFFFF,  3, -1, 32'hDEAD0001, 8'h00));
        vecs.push_back(mk("way7",      3'd7, 3'd0, 16'hFFFF, -1, -1, 32'h0F0F0F0F, 8'h80));
        vecs.push_back(mk("abort8",    3'd6, 3'd0, 16'hFFFF,  7, -1, 32'hBEEF0003, 8'h00));
        vecs.push_back(mk("busystart", 3'd3, 3'd0, 16'hFFFF, -1,  2, 32'h12345679, 8'h08));
        vecs.push_back(mk("way2",      3'd2, 3'd0, 16'h5555, -1, -1, 32'h9E3779B9, 8'h04));
        vecs.push_back(mk("way1",      3'd1, 3'd0, 16'hB6D3, -1, -1, 32'h7F4A7C15, 8'h02));
`ifdef CRITICAL_WORD_FIRST_EN
        vecs.push_back(mk("cwf6",      3'd4, 3'd6, 16'hFFFF, -1, -1, 32'h0A0A0A0A, 8'h10));
`endif

        repeat (2) @(negedge clk);
        check("rst_way_we", {248'd0, way_we}, 256'd0);
        check("rst_blockIn", blockIn, 256'd0);
        check("rst_mem_ready", {255'd0, mem_ready}, 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_fill_done", {255'd0, fill_done}, 256'd0);
        rst = 1'b0;
        started = 1'b1;

        // mem_valid in IDLE must be ignored
        mem_valid = 1'b1; mem_data = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_mem_ready", {255'd0, mem_ready}, 256'd0);
            check("idle_busy", {255'd0, busy}, 256'd0);
        end
        check("idle_blockIn", blockIn, model_blk);
        mem_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            do_fill(vecs[i], lat);
            if (i == 0) begin
                // start sampled in cycle 1, strobe visible in cycle 10
                check("basic_latency", lat, 9);
                check("basic_word0", {224'd0, blockIn[31:0]}, {224'd0, 32'h11111111});
                check("basic_word7", {224'd0, blockIn[255:224]}, {224'd0, 32'h88888888});
            end
`ifdef CRITICAL_WORD_FIRST_EN
            if (vecs[i].name == "cwf6") begin
                check("cwf_word6", {224'd0, blockIn[6*32 +: 32]}, {224'd0, 32'h0A0A0A0A});
                check("cwf_word0", {224'd0, blockIn[31:0]}, {224'd0, 32'h1E1E1E1E});
                check("cwf_word5", {224'd0, blockIn[5*32 +: 32]}, {224'd0, 32'h50505050});
            end
`endif
        end

        // reset at beat 4 discards the fill
        fill_start = 1'b1; fill_way = 3'd6;
        @(negedge clk);
        fill_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_valid = 1'b1; mem_data = 32'h5A5A0000 + b;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_way_we", {248'd0, way_we}, 256'd0);
        check("midrst_blockIn", blockIn, 256'd0);
        check("midrst_mem_ready", {255'd0, mem_ready}, 256'd0);
        check("midrst_busy", {255'd0, busy}, 256'd0);
        check("midrst_fill_done", {255'd0, fill_done}, 256'd0);
        rst = 1'b0;
        model_blk = 256'd0;
        repeat (10) @(negedge clk);
        mem_valid = 1'b0;
        check("midrst_still_idle", {255'd0, busy}, 256'd0);

        do_fill(mk("post_rst", 3'd7, 3'd0, 16'hFFFF, -1, -1, 32'h31415927, 8'h80), lat);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
`ifdef CRITICAL_WORD_FIRST_EN
        check("crit_pulses", crit_seen, crit_exp);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
